// File: rtl/execute_pipe_if.sv
// ---------------------------------------------------------------------------
// execute_pipe_if -- bundle of the EX-stage operand and result signals.
//
// Parameter:
//   N            datapath width in bits
//
// Modports:
//   master  drives operands, forwarding selects and out_ready; observes
//           in_ready, the registered _M results, out_valid and busy
//           (the decode/hazard side and the memory stage together).
//   slave   the execute_pipe block itself.
//
// Signals:
//   in_valid / in_ready            operand handshake
//   AluSrc[1:0], AluControl[3:0]   B-operand select and ALU operation
//   op_mul                         multiply request
//   PC_E, signImm_E, readData1_E,
//   readData2_E, readData3_E       stage operands (N bits each)
//   fwdA, fwdB [1:0]               forwarding selects
//   fwd_mem, fwd_wb                forwarded values (N bits each)
//   out_valid / out_ready          result handshake
//   PCBranch_M, PCAbsBranch_M,
//   aluResult_M, writeData_M       registered results (N bits each)
//   zero_M                         registered zero flag
//   busy                           multiply in progress
// ---------------------------------------------------------------------------
interface execute_pipe_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   AluSrc;
    logic [3:0]   AluControl;
    logic         op_mul;
    logic [N-1:0] PC_E;
    logic [N-1:0] signImm_E;
    logic [N-1:0] readData1_E;
    logic [N-1:0] readData2_E;
    logic [N-1:0] readData3_E;
    logic [1:0]   fwdA;
    logic [1:0]   fwdB;
    logic [N-1:0] fwd_mem;
    logic [N-1:0] fwd_wb;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] PCBranch_M;
    logic [N-1:0] PCAbsBranch_M;
    logic [N-1:0] aluResult_M;
    logic [N-1:0] writeData_M;
    logic         zero_M;
    logic         busy;

    modport master (
        output in_valid, AluSrc, AluControl, op_mul,
        output PC_E, signImm_E, readData1_E, readData2_E, readData3_E,
        output fwdA, fwdB, fwd_mem, fwd_wb, out_ready,
        input  in_ready, out_valid, PCBranch_M, PCAbsBranch_M,
        input  aluResult_M, writeData_M, zero_M, busy
    );

    modport slave (
        input  in_valid, AluSrc, AluControl, op_mul,
        input  PC_E, signImm_E, readData1_E, readData2_E, readData3_E,
        input  fwdA, fwdB, fwd_mem, fwd_wb, out_ready,
        output in_ready, out_valid, PCBranch_M, PCAbsBranch_M,
        output aluResult_M, writeData_M, zero_M, busy
    );
endinterface

// File: rtl/execute_pipe.sv
// ---------------------------------------------------------------------------
// execute_pipe -- EX stage of a pipelined core with an EX/MEM output register.
//
// Computes forwarded operands, the ALU result, the zero flag and the branch
// targets, and registers them behind a valid/ready handshake. Optionally
// contains an iterative shift-add multiplier (N cycles + 1 writeback cycle).
//
// Parameters:
//   N        datapath width in bits (N >= 8)
//   FWD_EN   1: forwarding muxes present; 0: fwdA/fwdB ignored (register file)
//
// Compile-time option:
//   EXECUTE_PIPE_MUL_EN   define to build the multiply FSM and datapath;
//                         when undefined op_mul is ignored and busy is 0.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset
//   bus     execute_pipe_if.slave (operands, forwarding, results, handshake)
// ---------------------------------------------------------------------------
module execute_pipe #(
    parameter int N      = 64,
    parameter int FWD_EN = 1
) (
    input  logic          clk,
    input  logic          reset,
    execute_pipe_if.slave bus
);

    // -----------------------------------------------------------------------
    // Operand selection
    // -----------------------------------------------------------------------
    logic [N-1:0] op_a;       // forwarded A
    logic [N-1:0] op_b_pre;   // forwarded B before the AluSrc mux (store data)
    logic [N-1:0] op_b;       // ALU B input

    generate
        if (FWD_EN != 0) begin : g_fwd
            always_comb begin
                case (bus.fwdA)
                    2'b01:   op_a = bus.fwd_mem;
                    2'b10:   op_a = bus.fwd_wb;
                    default: op_a = bus.readData1_E;
                endcase
            end

            always_comb begin
                case (bus.fwdB)
                    2'b01:   op_b_pre = bus.fwd_mem;
                    2'b10:   op_b_pre = bus.fwd_wb;
                    default: op_b_pre = bus.readData2_E;
                endcase
            end
        end else begin : g_no_fwd
            logic unused_fwd;
            assign op_a       = bus.readData1_E;
            assign op_b_pre   = bus.readData2_E;
            assign unused_fwd = ^{bus.fwdA, bus.fwdB, bus.fwd_mem, bus.fwd_wb};
        end
    endgenerate

    always_comb begin
        case (bus.AluSrc)
            2'b00:   op_b = op_b_pre;
            2'b01:   op_b = bus.signImm_E;
            default: op_b = bus.readData3_E;
        endcase
    end

    // -----------------------------------------------------------------------
    // ALU
    // -----------------------------------------------------------------------
    logic [N-1:0] and_y;
    logic [N-1:0] or_y;
    logic [N-1:0] alu_y;
    logic [N-1:0] pc_branch;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bitwise
            assign and_y[gi] = op_a[gi] & op_b[gi];
            assign or_y[gi]  = op_a[gi] | op_b[gi];
        end
    endgenerate

    always_comb begin
        alu_y = '0;
        case (bus.AluControl)
            4'b0000: alu_y = and_y;
            4'b0001: alu_y = or_y;
            4'b0010: alu_y = op_a + op_b;
            4'b0110: alu_y = op_a - op_b;
            4'b0111: alu_y = op_b;
            4'b1100: alu_y = ~or_y;
            default: alu_y = '0;
        endcase
    end

    assign pc_branch = bus.PC_E + (bus.signImm_E << 2);

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic         out_valid_reg;
    logic         busy_int;
    logic         in_ready_int;
    logic         transfer;
    logic         load_alu;     // single-cycle result loads the _M registers
    logic         load_mul;     // multiply result loads the _M registers
    logic [N-1:0] mul_result;
    logic [N-1:0] mul_pcb;
    logic [N-1:0] mul_pabs;
    logic [N-1:0] mul_wd;

    assign in_ready_int = !busy_int && (!out_valid_reg || bus.out_ready);
    assign transfer     = bus.in_valid && in_ready_int;

`ifdef EXECUTE_PIPE_MUL_EN
    // -----------------------------------------------------------------------
    // Multiply FSM: IDLE -> MUL (N shift-add steps) -> DONE (writeback)
    // -----------------------------------------------------------------------
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic          mul_start;
    logic          mul_last;
    logic          done_load;
    logic [N-1:0]  mul_a_reg;
    logic [N-1:0]  mul_b_reg;
    logic [N-1:0]  mul_acc_reg;
    logic [N-1:0]  cap_pcb_reg;
    logic [N-1:0]  cap_pabs_reg;
    logic [N-1:0]  cap_wd_reg;
    logic [CW-1:0] count_reg;

    // A transfer can only complete in IDLE because busy blocks in_ready.
    assign mul_start = transfer && bus.op_mul;
    assign mul_last  = (count_reg == CW'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mul_start) state_next = MUL;
            MUL:     if (mul_last) state_next = DONE;
            DONE:    if (!out_valid_reg || bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_int  = 1'b0;
        done_load = 1'b0;
        case (state_reg)
            MUL: begin
                busy_int = 1'b1;
            end
            DONE: begin
                busy_int  = 1'b1;
                done_load = !out_valid_reg || bus.out_ready;
            end
            default: begin
                busy_int  = 1'b0;
                done_load = 1'b0;
            end
        endcase
    end

    // Shift-add: A shifts left, B shifts right, add A when B's LSB is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_a_reg    <= '0;
            mul_b_reg    <= '0;
            mul_acc_reg  <= '0;
            count_reg    <= '0;
            cap_pcb_reg  <= '0;
            cap_pabs_reg <= '0;
            cap_wd_reg   <= '0;
        end else if (mul_start) begin
            mul_a_reg    <= op_a;
            mul_b_reg    <= op_b;
            mul_acc_reg  <= '0;
            count_reg    <= '0;
            cap_pcb_reg  <= pc_branch;
            cap_pabs_reg <= op_a;
            cap_wd_reg   <= op_b_pre;
        end else if (state_reg == MUL) begin
            if (mul_b_reg[0]) begin
                mul_acc_reg <= mul_acc_reg + mul_a_reg;
            end
            mul_a_reg <= mul_a_reg << 1;
            mul_b_reg <= mul_b_reg >> 1;
            count_reg <= count_reg + CW'(1);
        end
    end

    assign load_alu   = transfer && !bus.op_mul;
    assign load_mul   = done_load;
    assign mul_result = mul_acc_reg;
    assign mul_pcb    = cap_pcb_reg;
    assign mul_pabs   = cap_pabs_reg;
    assign mul_wd     = cap_wd_reg;
`else
    logic unused_op_mul;

    assign unused_op_mul = bus.op_mul;
    assign busy_int      = 1'b0;
    assign load_alu      = transfer;
    assign load_mul      = 1'b0;
    assign mul_result    = '0;
    assign mul_pcb       = '0;
    assign mul_pabs      = '0;
    assign mul_wd        = '0;
`endif

    // -----------------------------------------------------------------------
    // EX/MEM output register
    // -----------------------------------------------------------------------
    logic [N-1:0] pcb_reg;
    logic [N-1:0] pabs_reg;
    logic [N-1:0] alu_result_reg;
    logic [N-1:0] write_data_reg;
    logic         zero_reg;

    // A load is only possible when the register is empty or draining, so the
    // outputs hold automatically while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcb_reg        <= '0;
            pabs_reg       <= '0;
            alu_result_reg <= '0;
            write_data_reg <= '0;
            zero_reg       <= 1'b0;
            out_valid_reg  <= 1'b0;
        end else if (load_alu) begin
            pcb_reg        <= pc_branch;
            pabs_reg       <= op_a;
            alu_result_reg <= alu_y;
            write_data_reg <= op_b_pre;
            zero_reg       <= (alu_y == '0);
            out_valid_reg  <= 1'b1;
        end else if (load_mul) begin
            pcb_reg        <= mul_pcb;
            pabs_reg       <= mul_pabs;
            alu_result_reg <= mul_result;
            write_data_reg <= mul_wd;
            zero_reg       <= (mul_result == '0);
            out_valid_reg  <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign bus.in_ready      = in_ready_int;
    assign bus.out_valid     = out_valid_reg;
    assign bus.busy          = busy_int;
    assign bus.PCBranch_M    = pcb_reg;
    assign bus.PCAbsBranch_M = pabs_reg;
    assign bus.aluResult_M   = alu_result_reg;
    assign bus.writeData_M   = write_data_reg;
    assign bus.zero_M        = zero_reg;

endmodule
